// File: rtl/pll_seq_pkg.sv
// State encoding, default timing constants and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    localparam int DEF_RST_HOLD_CYC     = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 27000;  // 1 ms at 27 MHz
    localparam int DEF_STABLE_CYC       = 1024;
    localparam int DEF_MAX_RETRY        = 3;

    // One counter serves all timed states, so it is sized for the longest one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer into the core_clk domain, cleared to 0 on arst_n.
// Latency: 2 core_clk cycles. Backpressure: none, level signals only.
// Pulses narrower than a core_clk period may be missed.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] async_dat,
    output logic [WIDTH-1:0] sync_dat
);

    logic [WIDTH-1:0] meta_dat;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_dat <= '0;
            sync_dat <= '0;
        end else begin
            meta_dat <= async_dat;
            sync_dat <= meta_dat;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up the board PLL: hold its reset, wait for lock with bounded retries, qualify lock, release core reset.
// Latency: pll_lock rise to core_resetn rise is 2 sync cycles + 1 transition cycle + STABLE_CYC.
// Backpressure: none; relock_req is accepted in any state and overrides every other event that cycle.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic       sys_clk,
    input  logic       sys_resetn,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       core_resetn,
    output logic       locked,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    localparam int             CW           = cnt_width(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
    localparam logic [CW-1:0]  HOLD_LAST    = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [3:0]     RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_state_t    state_q;
    pll_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    retry_d;
    logic          lock_s;
    logic          lost_d;
    logic          restart;
    logic          counting;

    // The PLL lock pin is asynchronous to the board clock.
    sync2 #(
        .WIDTH(1)
    ) u_lock_sync (
        .core_clk  (sys_clk),
        .arst_n    (sys_resetn),
        .async_dat (pll_lock),
        .sync_dat  (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_cnt;
        lost_d   = 1'b0;
        restart  = 1'b0;
        counting = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_cnt + 4'd1;
                        state_d = HOLD;
                    end
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait but is not a failed attempt.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = HOLD;
                    lost_d  = 1'b1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (state_d == RUN) retry_d = 4'd0;

        if (relock_req) begin
            state_d = HOLD;
            retry_d = 4'd0;
            lost_d  = 1'b0;
        end

        // Counter restarts on any state change, and on a relock even from HOLD.
        restart  = relock_req || (state_d != state_q);
        counting = (state_d == HOLD) || (state_d == WAIT_LOCK) || (state_d == STABLE);
        if (restart) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so each state's outputs appear in its first cycle.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_cnt   <= 4'd0;
            pll_reset   <= 1'b1;
            core_resetn <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt   <= retry_d;
            pll_reset   <= (state_d == HOLD) || (state_d == FAIL);
            core_resetn <= (state_d == RUN);
            locked      <= (state_d == RUN);
            fail        <= (state_d == FAIL);
            lock_lost   <= lost_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with randomized lock timing against arithmetic expectations.
module tb_pll_lock_sequencer;

    localparam int H = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int M = 2;
    localparam int P = H + T;
    // Lock set between edges: two edges to synchronize, one to leave WAIT_LOCK, S in STABLE.
    localparam int LOCK_TO_RUN  = 2 + 1 + S;
    // Lock drop: two edges to synchronize, then the RUN->HOLD edge.
    localparam int DROP_TO_HOLD = 3;
    localparam int BOUND        = 500;

    logic       sys_clk    = 1'b0;
    logic       sys_resetn = 1'b0;
    logic       pll_lock   = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset;
    logic       core_resetn;
    logic       locked;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYC     (H),
        .LOCK_TIMEOUT_CYC (T),
        .STABLE_CYC       (S),
        .MAX_RETRY        (M)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_resetn  (sys_resetn),
        .pll_lock    (pll_lock),
        .relock_req  (relock_req),
        .pll_reset   (pll_reset),
        .core_resetn (core_resetn),
        .locked      (locked),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
    endtask

    task automatic steps_until_run(output int n);
        n = -1;
        for (int i = 1; i <= BOUND; i++) begin
            step(1);
            if (core_resetn === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic steps_until_pll_low(output int n);
        n = -1;
        for (int i = 1; i <= BOUND; i++) begin
            step(1);
            if (pll_reset === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0;
        pll_lock   = 1'b0;
        step(3);
        checks++; if (pll_reset !== 1'b1)   begin errors++; $display("FAIL reset_pll_reset: got %b expected 1", pll_reset); end
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL reset_core_resetn: got %b expected 0", core_resetn); end
        checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (fail !== 1'b0)        begin errors++; $display("FAIL reset_fail: got %b expected 0", fail); end
        checks++; if (lock_lost !== 1'b0)   begin errors++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
        checks++; if (retry_cnt !== 4'd0)   begin errors++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_lock_sequence();
        int n;
        int d;
        sys_resetn = 1'b1;
        steps_until_pll_low(n);
        checks++; if (n != H) begin errors++; $display("FAIL hold_len: got %0d expected %0d", n, H); end
        d = (3 > 0) ? 3 : 0;
        d = d + $urandom_range(0, 9);
        step(d);
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL wait_core_resetn: got %b expected 0", core_resetn); end
        pll_lock = 1'b1;
        steps_until_run(n);
        checks++; if (n != LOCK_TO_RUN) begin errors++; $display("FAIL lock_to_run: got %0d expected %0d", n, LOCK_TO_RUN); end
        checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL run_locked: got %b expected 1", locked); end
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL run_pll_reset: got %b expected 0", pll_reset); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL run_retry_cnt: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_timeout_fail();
        int a;
        int ph;
        logic       exp_pr;
        logic       exp_fail;
        logic [3:0] exp_retry;
        pll_lock   = 1'b0;
        sys_resetn = 1'b0;
        step(2);
        sys_resetn = 1'b1;
        for (int k = 1; k <= (M + 1) * P + 20; k++) begin
            step(1);
            a  = k / P;
            ph = k % P;
            if (a <= M) begin
                exp_pr    = (ph < H);
                exp_fail  = 1'b0;
                exp_retry = 4'(a);
            end else begin
                exp_pr    = 1'b1;
                exp_fail  = 1'b1;
                exp_retry = 4'(M);
            end
            checks++; if (pll_reset !== exp_pr)   begin errors++; $display("FAIL retry_pll_reset k=%0d: got %b expected %b", k, pll_reset, exp_pr); end
            checks++; if (retry_cnt !== exp_retry) begin errors++; $display("FAIL retry_cnt k=%0d: got %0d expected %0d", k, retry_cnt, exp_retry); end
            checks++; if (fail !== exp_fail)      begin errors++; $display("FAIL retry_fail k=%0d: got %b expected %b", k, fail, exp_fail); end
            checks++; if (core_resetn !== 1'b0)   begin errors++; $display("FAIL retry_core_resetn k=%0d: got %b expected 0", k, core_resetn); end
        end
    endtask

    task automatic test_relock_from_fail();
        int n;
        pulse_relock();
        checks++; if (fail !== 1'b0)      begin errors++; $display("FAIL relock_fail: got %b expected 0", fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL relock_retry: got %0d expected 0", retry_cnt); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL relock_pll_reset: got %b expected 1", pll_reset); end
        steps_until_pll_low(n);
        checks++; if (n != H) begin errors++; $display("FAIL relock_hold_len: got %0d expected %0d", n, H); end
        step($urandom_range(0, 12));
        pll_lock = 1'b1;
        steps_until_run(n);
        checks++; if (n != LOCK_TO_RUN) begin errors++; $display("FAIL relock_to_run: got %0d expected %0d", n, LOCK_TO_RUN); end
        checks++; if (fail !== 1'b0)    begin errors++; $display("FAIL relock_run_fail: got %b expected 0", fail); end
    endtask

    task automatic test_retry_then_lock();
        int n;
        pll_lock = 1'b0;
        pulse_relock();
        steps_until_pll_low(n);
        step(T);
        checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL one_retry: got %0d expected 1", retry_cnt); end
        pll_lock = 1'b1;
        steps_until_run(n);
        checks++; if (n != H + 1 + S)     begin errors++; $display("FAIL retry_lock_to_run: got %0d expected %0d", n, H + 1 + S); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL retry_cleared_in_run: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_stable_glitch();
        int n;
        int s;
        int g;
        logic early;
        for (int it = 0; it < 4; it++) begin
            pll_lock = 1'b0;
            pulse_relock();
            steps_until_pll_low(n);
            s = (it == 0) ? 8 : $urandom_range(4, 8);
            g = (it == 0) ? 3 : $urandom_range(1, 4);
            early = 1'b0;
            pll_lock = 1'b1;
            for (int i = 0; i < s; i++) begin step(1); if (core_resetn !== 1'b0) early = 1'b1; end
            pll_lock = 1'b0;
            for (int i = 0; i < g; i++) begin step(1); if (core_resetn !== 1'b0) early = 1'b1; end
            pll_lock = 1'b1;
            steps_until_run(n);
            checks++; if (early !== 1'b0)      begin errors++; $display("FAIL glitch_early_run s=%0d g=%0d: got %b expected 0", s, g, early); end
            checks++; if (n != LOCK_TO_RUN)    begin errors++; $display("FAIL glitch_fresh_window s=%0d g=%0d: got %0d expected %0d", s, g, n, LOCK_TO_RUN); end
            checks++; if (retry_cnt !== 4'd0)  begin errors++; $display("FAIL glitch_retry s=%0d g=%0d: got %0d expected 0", s, g, retry_cnt); end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        logic exp_run;
        for (int it = 0; it < 2; it++) begin
            step($urandom_range(1, 20));
            pll_lock = 1'b0;
            for (int i = 1; i < DROP_TO_HOLD + H; i++) begin
                step(1);
                exp_run = (i < DROP_TO_HOLD);
                checks++; if (core_resetn !== exp_run)  begin errors++; $display("FAIL loss_core_resetn i=%0d: got %b expected %b", i, core_resetn, exp_run); end
                checks++; if (locked !== exp_run)       begin errors++; $display("FAIL loss_locked i=%0d: got %b expected %b", i, locked, exp_run); end
                checks++; if (pll_reset !== !exp_run)   begin errors++; $display("FAIL loss_pll_reset i=%0d: got %b expected %b", i, pll_reset, !exp_run); end
                checks++; if (lock_lost !== (i == DROP_TO_HOLD)) begin errors++; $display("FAIL loss_pulse i=%0d: got %b expected %b", i, lock_lost, (i == DROP_TO_HOLD)); end
            end
            steps_until_pll_low(n);
            checks++; if (n != 1) begin errors++; $display("FAIL loss_hold_end: got %0d expected 1", n); end
            step($urandom_range(0, 10));
            pll_lock = 1'b1;
            steps_until_run(n);
            checks++; if (n != LOCK_TO_RUN) begin errors++; $display("FAIL loss_relock: got %0d expected %0d", n, LOCK_TO_RUN); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        step(1);
        #2 sys_resetn = 1'b0;
        #1;
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL async_run_core_resetn: got %b expected 0", core_resetn); end
        checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL async_run_locked: got %b expected 0", locked); end
        checks++; if (pll_reset !== 1'b1)   begin errors++; $display("FAIL async_run_pll_reset: got %b expected 1", pll_reset); end
        pll_lock = 1'b0;
        step(1);
        sys_resetn = 1'b1;
        steps_until_pll_low(n);
        pll_lock = 1'b1;
        step(3 + $urandom_range(0, S - 2));
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL stable_pll_reset: got %b expected 0", pll_reset); end
        #2 sys_resetn = 1'b0;
        #1;
        checks++; if (pll_reset !== 1'b1)   begin errors++; $display("FAIL async_stable_pll_reset: got %b expected 1", pll_reset); end
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL async_stable_core_resetn: got %b expected 0", core_resetn); end
        checks++; if (retry_cnt !== 4'd0)   begin errors++; $display("FAIL async_stable_retry: got %0d expected 0", retry_cnt); end
        pll_lock = 1'b0;
        step(1);
        sys_resetn = 1'b1;
        steps_until_pll_low(n);
        checks++; if (n != H) begin errors++; $display("FAIL post_reset_hold: got %0d expected %0d", n, H); end
    endtask

    task automatic test_relock_priority();
        int n;
        pll_lock = 1'b1;
        step(LOCK_TO_RUN - 1);
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL prio_before: got %b expected 0", core_resetn); end
        pulse_relock();
        checks++; if (pll_reset !== 1'b1)   begin errors++; $display("FAIL prio_pll_reset: got %b expected 1", pll_reset); end
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL prio_core_resetn: got %b expected 0", core_resetn); end
        checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL prio_locked: got %b expected 0", locked); end
        steps_until_run(n);
        checks++; if (n != H + 1 + S) begin errors++; $display("FAIL prio_rerun: got %0d expected %0d", n, H + 1 + S); end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout_fail();
        test_relock_from_fail();
        test_retry_then_lock();
        test_stable_glitch();
        test_lock_loss();
        test_async_reset();
        test_relock_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
